// File: rtl/usart_pkg.sv
// Shared USART definitions: FSM state encoding, oversampling and divider constants.
package usart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_MID = 8;
    localparam int unsigned DIV_W      = 12;
    localparam int unsigned SCNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Two-of-three vote used to decide each received bit
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/usart_baud_tick.sv
// Oversample tick generator: one registered pulse every clock_divider cycles.
module usart_baud_tick
    import usart_pkg::*;
(
    input  logic             comm_clock,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] clock_divider,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Down-counter; the divider is only sampled on reload, and 0/1 both give a tick every cycle
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == '0) begin
            tick_d = 1'b1;
            cnt_d  = (clock_divider > DIV_W'(1)) ? (clock_divider - DIV_W'(1)) : '0;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Counter and tick registers
    always_ff @(posedge comm_clock) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/usart_rx.sv
// 8N1-style USART receiver with x16 oversampling, majority voting and a one-entry holding register.
module usart_rx
    import usart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 comm_clock,
    input  logic                 reset_n,
    input  logic [DIV_W-1:0]     clock_divider,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                   tick;
    logic                   rx_s;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    rx_state_e              state_q;
    rx_state_e              state_d;
    logic [SCNT_W-1:0]      scnt_q;
    logic [SCNT_W-1:0]      scnt_d;
    logic [IDX_W-1:0]       bidx_q;
    logic [IDX_W-1:0]       bidx_d;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [DATA_BITS-1:0]   shreg_d;
    logic                   s7_q;
    logic                   s7_d;
    logic                   s8_q;
    logic                   s8_d;
    logic [DATA_BITS-1:0]   data_out_q;
    logic [DATA_BITS-1:0]   data_out_d;
    logic                   data_valid_q;
    logic                   data_valid_d;
    logic                   frame_error_q;
    logic                   frame_error_d;
    logic                   overrun_q;
    logic                   overrun_d;
    logic                   busy_q;
    logic                   busy_d;

    usart_baud_tick u_tick (
        .comm_clock    (comm_clock),
        .reset_n       (reset_n),
        .clock_divider (clock_divider),
        .tick          (tick)
    );

    // Shift the raw line into the synchroniser chain; the oldest stage is the usable sample
    always_comb begin
        sync_d = SYNC_STAGES'({sync_q, rx_pin});
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Frame FSM, bit sampling and holding-register handshake
    always_comb begin
        logic maj;
        logic at_dec;
        logic at_last;

        state_d       = state_q;
        scnt_d        = scnt_q;
        bidx_d        = bidx_q;
        shreg_d       = shreg_q;
        s7_d          = s7_q;
        s8_d          = s8_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        maj           = majority3(s7_q, s8_q, rx_s);
        at_dec        = (scnt_q == SCNT_W'(SAMPLE_MID + 1));
        at_last       = (scnt_q == SCNT_W'(OVERSAMPLE - 1));

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        if (tick) begin
            if (state_q == ST_IDLE) begin
                if (!rx_s) begin
                    state_d = ST_START;
                    scnt_d  = '0;
                end
            end else begin
                scnt_d = scnt_q + SCNT_W'(1);
                if (scnt_q == SCNT_W'(SAMPLE_MID - 1)) begin
                    s7_d = rx_s;
                end
                if (scnt_q == SCNT_W'(SAMPLE_MID)) begin
                    s8_d = rx_s;
                end

                case (state_q)
                    ST_START: begin
                        if (at_dec && maj) begin
                            state_d = ST_IDLE;
                            scnt_d  = '0;
                        end else if (at_last) begin
                            state_d = ST_DATA;
                            bidx_d  = '0;
                        end
                    end
                    ST_DATA: begin
                        if (at_dec) begin
                            shreg_d = DATA_BITS'({maj, shreg_q} >> 1);
                        end
                        if (at_last) begin
                            if (bidx_q == IDX_W'(DATA_BITS - 1)) begin
                                state_d = ST_STOP;
                            end else begin
                                bidx_d = bidx_q + IDX_W'(1);
                            end
                        end
                    end
                    ST_STOP: begin
                        // Resolve at mid-stop so the next start edge can be caught immediately
                        if (at_dec) begin
                            state_d = ST_IDLE;
                            scnt_d  = '0;
                            if (maj) begin
                                if (!data_valid_q || data_ready) begin
                                    data_out_d   = shreg_q;
                                    data_valid_d = 1'b1;
                                end else begin
                                    overrun_d = 1'b1;
                                end
                            end else begin
                                frame_error_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge comm_clock) begin
        if (!reset_n) begin
            sync_q        <= '1;
            state_q       <= ST_IDLE;
            scnt_q        <= '0;
            bidx_q        <= '0;
            shreg_q       <= '0;
            s7_q          <= 1'b1;
            s8_q          <= 1'b1;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            scnt_q        <= scnt_d;
            bidx_q        <= bidx_d;
            shreg_q       <= shreg_d;
            s7_q          <= s7_d;
            s8_q          <= s8_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx: table of single frames plus back-to-back, glitch and reset sequences.
module tb_usart_rx;

    localparam int unsigned BIT_CYC = 32;

    logic        comm_clock    = 1'b0;
    logic        reset_n       = 1'b0;
    logic [11:0] clock_divider = 12'd2;
    logic        rx_pin        = 1'b1;
    logic        data_ready    = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        frame_error;
    logic        overrun;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (written only by the monitor process)
    int         n_rise    = 0;
    int         n_fe_rise = 0;
    int         n_fe_cyc  = 0;
    int         n_ov_cyc  = 0;
    int         hold_err  = 0;
    logic       vp        = 1'b0;
    logic       fp        = 1'b0;
    logic [7:0] dp        = 8'h00;
    logic [7:0] got_data [64];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_dout;
        int         exp_rise;
        int         exp_fe;
        int         exp_ov;
        logic       drain;
    } vec_t;

    vec_t vecs [6];

    always #5 comm_clock = ~comm_clock;

    usart_rx dut (
        .comm_clock    (comm_clock),
        .reset_n       (reset_n),
        .clock_divider (clock_divider),
        .rx_pin        (rx_pin),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .frame_error   (frame_error),
        .overrun       (overrun),
        .busy          (busy)
    );

    // Event counters sampled on the falling edge
    always @(negedge comm_clock) begin
        if (reset_n) begin
            if (data_valid && !vp) begin
                got_data[n_rise % 64] <= data_out;
                n_rise <= n_rise + 1;
            end
            if (vp && data_valid && (data_out != dp)) hold_err <= hold_err + 1;
            if (frame_error && !fp) n_fe_rise <= n_fe_rise + 1;
            if (frame_error) n_fe_cyc <= n_fe_cyc + 1;
            if (overrun) n_ov_cyc <= n_ov_cyc + 1;
            vp <= data_valid;
            fp <= frame_error;
            dp <= data_out;
        end else begin
            vp <= 1'b0;
            fp <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge comm_clock);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input int nbits);
        rx_pin = 1'b0;
        wait_cyc(BIT_CYC);
        for (int b = 0; b < nbits; b++) begin
            rx_pin = d[b];
            wait_cyc(BIT_CYC);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, 8);
        rx_pin = stop;
        wait_cyc(BIT_CYC);
        rx_pin = 1'b1;
    endtask

    initial begin
        int r0;
        int f0;
        int fc0;
        int o0;

        //           data   stop  rdy   vld   dout  rise fe ov drain
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1, 0, 0, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 1, 0, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1, 0, 0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0, 1, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1, 0, 0, 1'b0};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, 1, 0, 0, 1'b0};

        // Reset state
        wait_cyc(5);
        @(negedge comm_clock);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_fe", 32'(frame_error), 32'd0);
        check("rst_ov", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        wait_cyc(1);
        reset_n = 1'b1;
        wait_cyc(8);

        // Single frames from the vector table
        for (int i = 0; i < 6; i++) begin
            data_ready = vecs[i].ready;
            r0  = n_rise;
            f0  = n_fe_rise;
            fc0 = n_fe_cyc;
            o0  = n_ov_cyc;
            send_frame(vecs[i].data, vecs[i].stop);
            wait_cyc(2 * BIT_CYC);
            @(negedge comm_clock);
            check($sformatf("v%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
            check($sformatf("v%0d_rise", i), 32'(n_rise - r0), 32'(vecs[i].exp_rise));
            check($sformatf("v%0d_fe_pulses", i), 32'(n_fe_rise - f0), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_fe_cycles", i), 32'(n_fe_cyc - fc0), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_ov_cycles", i), 32'(n_ov_cyc - o0), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            if (vecs[i].drain) begin
                data_ready = 1'b1;
                wait_cyc(1);
                data_ready = vecs[i].ready;
                @(negedge comm_clock);
                check($sformatf("v%0d_drain_valid", i), 32'(data_valid), 32'd0);
                check($sformatf("v%0d_drain_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
            end
        end

        // Back-to-back frames with the consumer always ready
        data_ready = 1'b1;
        r0  = n_rise;
        f0  = n_fe_rise;
        o0  = n_ov_cyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h80, 1'b1);
        wait_cyc(2 * BIT_CYC);
        @(negedge comm_clock);
        check("b2b_count", 32'(n_rise - r0), 32'd4);
        check("b2b_d0", 32'(got_data[(r0 + 0) % 64]), 32'h00);
        check("b2b_d1", 32'(got_data[(r0 + 1) % 64]), 32'hFF);
        check("b2b_d2", 32'(got_data[(r0 + 2) % 64]), 32'h55);
        check("b2b_d3", 32'(got_data[(r0 + 3) % 64]), 32'h80);
        check("b2b_fe", 32'(n_fe_rise - f0), 32'd0);
        check("b2b_ov", 32'(n_ov_cyc - o0), 32'd0);
        check("b2b_valid", 32'(data_valid), 32'd0);

        // Short low glitch: enters START, then rejected at the mid-bit vote
        r0 = n_rise;
        f0 = n_fe_rise;
        rx_pin = 1'b0;
        wait_cyc(6);
        rx_pin = 1'b1;
        wait_cyc(4);
        @(negedge comm_clock);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        wait_cyc(20);
        @(negedge comm_clock);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        wait_cyc(2 * BIT_CYC);
        @(negedge comm_clock);
        check("glitch_rise", 32'(n_rise - r0), 32'd0);
        check("glitch_fe", 32'(n_fe_rise - f0), 32'd0);

        // Reset asserted in the middle of data bit 4 of 0x5A
        r0 = n_rise;
        f0 = n_fe_rise;
        send_bits(8'h5A, 4);
        rx_pin = 1'b1;
        wait_cyc(BIT_CYC / 2);
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        wait_cyc(4);
        @(negedge comm_clock);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dout", 32'(data_out), 32'd0);
        check("mid_rst_valid", 32'(data_valid), 32'd0);
        wait_cyc(1);
        reset_n = 1'b1;
        wait_cyc(2 * BIT_CYC);
        @(negedge comm_clock);
        check("mid_no_rise", 32'(n_rise - r0), 32'd0);
        check("mid_no_fe", 32'(n_fe_rise - f0), 32'd0);
        send_frame(8'h5A, 1'b1);
        wait_cyc(2 * BIT_CYC);
        @(negedge comm_clock);
        check("after_rst_rise", 32'(n_rise - r0), 32'd1);
        check("after_rst_data", 32'(got_data[r0 % 64]), 32'h5A);
        check("after_rst_dout", 32'(data_out), 32'h5A);

        check("hold_stable", 32'(hold_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usart_rx.md
USART_RX -- requirements
Module: usart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (8N1 framing, LSB first).
REQ-002 Parameter SYNC_STAGES, default 2, number of input synchroniser flops on rx_pin.
REQ-003 comm_clock  input  1  Sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  Synchronous, active-low reset, sampled on the comm_clock rising edge.
REQ-005 clock_divider  input  12  comm_clock cycles per x16 oversample tick.
REQ-006 rx_pin  input  1  Asynchronous serial line; idle high.
REQ-007 data_out  output  DATA_BITS  Received byte; held stable while data_valid=1.
REQ-008 data_valid  output  1  data_out holds an unconsumed byte.
REQ-009 data_ready  input  1  Consumer accepts data_out this cycle when data_valid=1.
REQ-010 frame_error  output  1  One-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  One-cycle pulse: new byte dropped because holding register was full.
REQ-012 busy  output  1  High in any state other than IDLE.

Function
REQ-013 The tick generator SHALL pulse once every clock_divider cycles; values 0 and 1 SHALL both mean every cycle; a divider change SHALL take effect at the next counter reload.
REQ-014 rx_pin SHALL pass through SYNC_STAGES flops before any use; the synchronised value is rx_s.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP; the sample counter is 4 bits, wraps 15->0, and advances only on ticks.
REQ-016 IDLE: on a tick with rx_s=0 -> START with the sample counter cleared.
REQ-017 Each bit value SHALL be the majority of rx_s at sample counts 7, 8 and 9; the decision is made at count 9.
REQ-018 START: majority=1 at count 9 -> IDLE (false start, no output); otherwise continue until count 15 wraps, then enter DATA with bit index 0.
REQ-019 DATA: shift in the majority at count 9, LSB first; after bit DATA_BITS-1 completes count 15 -> STOP.
REQ-020 STOP: at count 9, return to IDLE and resolve the frame the same cycle, so back-to-back frames are tolerated.
REQ-021 Stop majority=1 with data_valid=0, or data_valid=1 and data_ready=1 in the same cycle: load data_out and set data_valid on the next edge (single-cycle latency).
REQ-022 Stop majority=1 with data_valid=1 and data_ready=0: drop the new byte, retain data_out, pulse overrun.
REQ-023 Stop majority=0: discard the byte, pulse frame_error, leave data_out/data_valid untouched.
REQ-024 data_valid SHALL clear on the edge after data_valid=1 and data_ready=1 unless REQ-021 reloads it in the same cycle.
REQ-025 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-026 When reset_n=0: FSM->IDLE; sample counter, bit index and tick counter->0; synchroniser flops->1; data_out->0; data_valid, frame_error, overrun, busy->0.
REQ-027 A reset mid-frame SHALL abandon the frame with no output; reception resumes at the next falling edge after reset_n=1.

Structure
REQ-028 A shared package usart_pkg SHALL hold the FSM state enum, OVERSAMPLE=16, SAMPLE_MID=8 and the 12-bit divider width constant, for reuse by the transmitter.
REQ-029 The tick generator SHALL be a sub-module named usart_baud_tick (ports comm_clock, reset_n, clock_divider, tick).

Verification
REQ-030 clock_divider=2; send 0xA5 with 8N1 at 32 clocks/bit -> data_out=0xA5, data_valid=1, frame_error=0, overrun=0.
REQ-031 rx_pin low for 3 ticks only (glitch) -> FSM back in IDLE by count 9; no data_valid, no frame_error.
REQ-032 0x3C sent with the stop bit held low -> frame_error pulses exactly 1 cycle; data_valid stays 0.
REQ-033 data_ready=0; send 0x11 then 0x22 -> data_out=0x11 retained, overrun pulses once; after data_ready=1 for one cycle -> data_valid=0.
REQ-034 data_ready=1 permanently; 4 back-to-back frames 0x00, 0xFF, 0x55, 0x80 -> four valid cycles with those values in order; no errors.
REQ-035 reset_n=0 asserted during DATA bit 4 of 0x5A -> no output; 0x5A then sent after reset_n=1 -> received intact.
